deser8: RTL and testbench
=========================

DESER8 -- requirements
Module: deser8

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the number of serial bits assembled into one output word.
REQ-002 The block SHALL have port clock, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit, meaning in_bit carries a serial bit this cycle.
REQ-005 The block SHALL have port in_bit, input, 1 bit, meaning the serial data bit, LSB first.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts in_bit this cycle.
REQ-007 The block SHALL have port abort, input, 1 bit, meaning discard the partially assembled word.
REQ-008 The block SHALL have port out_data, output, WIDTH bits, meaning the assembled word.
REQ-009 The block SHALL have port out_valid, output, 1 bit, meaning out_data holds an unconsumed word.
REQ-010 The block SHALL have port out_ready, input, 1 bit, meaning the consumer takes out_data this cycle.
REQ-011 The block SHALL have port out_parity, output, 1 bit, meaning the XOR of all bits of out_data.

Function
REQ-012 A serial bit SHALL be accepted exactly when in_valid and in_ready are both high at a rising clock edge.
REQ-013 The first accepted bit of a word SHALL land in out_data[0] and the WIDTH-th in out_data[WIDTH-1].
REQ-014 A bit counter SHALL run 0..WIDTH-1 and increment by one per accepted bit.
REQ-015 When the counter is WIDTH-1 and a bit is accepted, the counter SHALL wrap to 0.
REQ-016 On that same edge, the assembled word SHALL load into the output register and out_valid SHALL rise.
REQ-017 Latency SHALL be one cycle: out_valid is high in the cycle after the last bit is accepted.
REQ-018 out_valid SHALL stay high and out_data and out_parity SHALL stay stable until out_valid and out_ready are both high at an edge.
REQ-019 in_ready SHALL be low only when out_valid is high, out_ready is low, and the counter equals WIDTH-1.
REQ-020 When a word completes while a pending word is consumed in the same edge, the block SHALL take the new word without a bubble and keep out_valid high.
REQ-021 in_ready SHALL be high while a partial word of fewer than WIDTH-1 bits is accumulating, even with a pending output.
REQ-022 When abort is high at an edge, the counter and shift register SHALL clear to 0 and any bit on that edge SHALL be discarded.
REQ-023 abort SHALL NOT affect out_valid, out_data or out_parity.
REQ-024 out_parity SHALL be computed when the output register loads and registered with it.
REQ-025 The block SHALL NOT produce a word from fewer than WIDTH accepted bits.
REQ-026 in_ready SHALL be a combinational function of registered state and out_ready only.

Reset
REQ-027 Asserting reset_n low SHALL clear, asynchronously, the counter, the shift register, out_data, out_parity and out_valid to 0.
REQ-028 While reset_n is low, in_ready SHALL be 1, since out_valid is 0.
REQ-029 Reset in the middle of a word SHALL discard the partial word; the first bit after release is bit 0 of a new word.

Structure
REQ-030 A shared package SHALL hold the WIDTH default of 8 and the counter width, clog2(WIDTH), equal to 3.
REQ-031 The serial-in/parallel-out shift register SHALL be one sub-module, deser8_shift, with clear and shift-enable inputs.
REQ-032 The counter, the output register and the handshake logic SHALL reside in deser8.

Verification
REQ-033 Reset, then 8 accepted bits 1,0,1,0,0,1,0,1 with out_ready=1 -> out_data=8'hA5, out_parity=0, out_valid high for exactly one cycle.
REQ-034 Back-to-back words 8'hFF and 8'h01, each sent as 8 contiguous bits with out_ready=1 -> two single-cycle out_valid pulses 8 cycles apart, parity 0 then 1.
REQ-035 Word 8'h3C held with out_ready=0 while 7 bits of the next word arrive -> in_ready drops before the 8th bit; raising out_ready passes 8'h3C and then the next word intact.
REQ-036 4 bits 1,1,1,1, then abort, then 8'h81 -> only out_data=8'h81 appears.
REQ-037 reset_n pulsed low after 5 bits of a word, with a pending word 8'h55 -> out_valid=0 immediately; the next 8 bits form a fresh word.
REQ-038 Word completes on the same edge that out_ready consumes a pending word -> no lost word and no out_valid gap.

Source files
------------

// File: rtl/deser8_pkg.sv
// Shared constants and helpers for the deser8 serial-to-parallel deserializer.
package deser8_pkg;

    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int unsigned DESER_WIDTH = 8;
    localparam int unsigned DESER_CNT_W = cnt_width(DESER_WIDTH);

endpackage

// File: rtl/deser8_shift.sv
// LSB-first serial-in/parallel-out shift register with synchronous clear.
module deser8_shift
    import deser8_pkg::*;
#(
    parameter int unsigned WIDTH = DESER_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             in_bit,
    output logic [WIDTH-1:0] word_c
);

    logic [WIDTH-1:0] sr;

    // New bits enter at the top so the first bit of a word ends up in bit 0.
    assign word_c = (sr >> 1) | (WIDTH'(in_bit) << (WIDTH - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr <= '0;
        end else if (clear) begin
            sr <= '0;
        end else if (shift_en) begin
            sr <= word_c;
        end
    end

endmodule

// File: rtl/deser8.sv
// Deserializer: assembles WIDTH accepted serial bits into one word with a
// valid/ready output register and registered parity.
module deser8
    import deser8_pkg::*;
#(
    parameter int unsigned WIDTH = DESER_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    input  logic             abort,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity
);

    localparam int unsigned     CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] word_c;
    logic             at_last_c;
    logic             accept_c;
    logic             complete_c;
    logic             consume_c;

    // Only the final bit of a word can be stalled, and only by an unconsumed output.
    assign at_last_c  = (cnt == LAST);
    assign in_ready   = !(out_valid && !out_ready && at_last_c);
    assign accept_c   = in_valid && in_ready && !abort;
    assign complete_c = accept_c && at_last_c;
    assign consume_c  = out_valid && out_ready;

    deser8_shift #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (abort),
        .shift_en (accept_c),
        .in_bit   (in_bit),
        .word_c   (word_c)
    );

    // Bit counter: wraps on the last bit, cleared by abort.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (abort) begin
            cnt <= '0;
        end else if (accept_c) begin
            cnt <= at_last_c ? '0 : cnt + CNT_W'(1);
        end
    end

    // Output register: a completing word wins over a same-edge consume, so no bubble.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_data   <= '0;
            out_parity <= 1'b0;
            out_valid  <= 1'b0;
        end else if (complete_c) begin
            out_data   <= word_c;
            out_parity <= ^word_c;
            out_valid  <= 1'b1;
        end else if (consume_c) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_deser8.sv
// Scoreboard bench for deser8: a bit-queue reference model predicts words and
// in_ready; a monitor pops expected words on every output handshake.
module tb_deser8;

    logic       clock;
    logic       reset_n;
    logic       in_valid;
    logic       in_bit;
    logic       in_ready;
    logic       abort;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_parity;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb_q[$];
    logic [7:0] seen[$];
    bit         mbits[$];
    bit         m_valid = 1'b0;

    deser8 #(.WIDTH(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .in_ready   (in_ready),
        .abort      (abort),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_parity (out_parity)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: predicts in_ready/out_valid and pushes each completed word.
    always @(negedge clock) begin
        bit         exp_ready;
        logic [7:0] w;
        if (!reset_n) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd1);
            check("rst_out_data", 32'(out_data), 32'd0);
            check("rst_out_parity", 32'(out_parity), 32'd0);
            mbits.delete();
            sb_q.delete();
            m_valid = 1'b0;
        end else begin
            exp_ready = !(m_valid && !out_ready && mbits.size() == 7);
            check("in_ready", 32'(in_ready), 32'(exp_ready));
            check("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid && out_ready) m_valid = 1'b0;
            if (abort) begin
                mbits.delete();
            end else if (in_valid && exp_ready) begin
                mbits.push_back(in_bit);
                if (mbits.size() == 8) begin
                    w = '0;
                    for (int i = 0; i < 8; i++) w[i] = mbits[i];
                    sb_q.push_back(w);
                    mbits.delete();
                    m_valid = 1'b1;
                end
            end
        end
    end

    // Monitor: every handshake consumes the oldest predicted word.
    always @(negedge clock) begin
        logic [7:0] e;
        if (reset_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_word actual=%0h required=none at %0t", out_data, $time);
            end else begin
                e = sb_q.pop_front();
                check("out_data", 32'(out_data), 32'(e));
                check("out_parity", 32'(out_parity), 32'($countones(e) & 1));
            end
            seen.push_back(out_data);
        end
    end

    task automatic step(input bit iv, input bit ib, input bit ab, input bit ordy);
        in_valid  = iv;
        in_bit    = ib;
        abort     = ab;
        out_ready = ordy;
        @(posedge clock);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input bit ordy);
        for (int i = 0; i < 8; i++) step(1'b1, w[i], 1'b0, ordy);
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, ordy);
    endtask

    task automatic check_seen(input string name, input logic [7:0] a, input logic [7:0] b, input int n);
        check({name, "_count"}, 32'(seen.size()), 32'(n));
        if (seen.size() > 0) check({name, "_w0"}, 32'(seen[0]), 32'(a));
        if (n > 1 && seen.size() > 1) check({name, "_w1"}, 32'(seen[1]), 32'(b));
        seen.delete();
    endtask

    initial begin
        logic [7:0] nxt;
        logic [7:0] part;
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        idle(2, 1'b1);

        // Single word A5, one-cycle valid pulse
        send_word(8'hA5, 1'b1);
        check("a5_valid", 32'(out_valid), 32'd1);
        check("a5_data", 32'(out_data), 32'hA5);
        check("a5_parity", 32'(out_parity), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("a5_pulse_end", 32'(out_valid), 32'd0);
        idle(2, 1'b1);
        check_seen("a5", 8'hA5, 8'h00, 1);

        // Back-to-back FF then 01
        send_word(8'hFF, 1'b1);
        check("ff_parity", 32'(out_parity), 32'd0);
        send_word(8'h01, 1'b1);
        check("01_parity", 32'(out_parity), 32'd1);
        idle(2, 1'b1);
        check_seen("b2b", 8'hFF, 8'h01, 2);

        // Backpressure: 3C pending, 7 bits of next word, stall, then same-edge complete+consume
        nxt = 8'h9A;
        send_word(8'h3C, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, nxt[i], 1'b0, 1'b0);
        check("stall_ready_low", 32'(in_ready), 32'd0);
        step(1'b1, nxt[7], 1'b0, 1'b0);
        step(1'b1, nxt[7], 1'b0, 1'b0);
        check("stall_hold_data", 32'(out_data), 32'h3C);
        step(1'b1, nxt[7], 1'b0, 1'b1);
        check("nobubble_valid", 32'(out_valid), 32'd1);
        check("nobubble_data", 32'(out_data), 32'h9A);
        idle(2, 1'b1);
        check_seen("bp", 8'h3C, 8'h9A, 2);

        // Abort discards a partial word
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        send_word(8'h81, 1'b1);
        idle(2, 1'b1);
        check_seen("abort", 8'h81, 8'h00, 1);

        // Reset mid-word with a pending output
        part = 8'h6B;
        send_word(8'h55, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, part[i], 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1 reset_n = 1'b1;
        send_word(8'hC3, 1'b1);
        idle(2, 1'b1);
        check_seen("midrst", 8'hC3, 8'h00, 1);

        // Randomized traffic with occasional abort and reset
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0;
                @(posedge clock);
                #1 reset_n = 1'b1;
            end
            step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 39) == 0,
                 $urandom_range(0, 1) == 1);
        end
        idle(20, 1'b1);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
